cfg_obi_master: RTL and testbench

CFG_OBI_MASTER -- requirements
Module: cfg_obi_master

---
 rtl/cfg_obi_master_if.sv | 23 ++
 rtl/cfg_obi_master.sv | 181 ++++++++++++++++++
 tb/tb_cfg_obi_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_obi_master_if.sv
// OBI request and response channel bundles used by cfg_obi_master.
// The request channel carries the address phase; the response channel
// carries read data back from the register slave.

interface obi_req_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;

    modport master (output req, output we, output be, output addr, output wdata, input gnt);
    modport slave  (input req, input we, input be, input addr, input wdata, output gnt);
endinterface

interface obi_rsp_if;
    logic        rvalid;
    logic [31:0] rdata;

    modport slave  (input rvalid, input rdata);
    modport master (output rvalid, output rdata);
endinterface

// File: rtl/cfg_obi_master.sv
// Single-outstanding OBI master: turns a valid/ready command into one OBI
// transaction and returns a valid/ready response. A per-transaction timeout
// converts a missing gnt or rvalid into an error response. After a response
// timeout, the late rvalid (if it ever arrives) is swallowed before new
// commands are admitted.

module cfg_obi_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [3:0]  cmd_be_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    obi_req_if.master   regs_req,
    obi_rsp_if.slave    regs_rsp
);

    // A zero timeout disables the counters; keep them one bit wide so the
    // declarations stay legal.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q,     state_d;
    logic              we_q,        we_d;
    logic [31:0]       addr_q,      addr_d;
    logic [3:0]        be_q,        be_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic              err_q,       err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              stale_q,     stale_d;
    logic [CNT_W-1:0]  stale_cnt_q, stale_cnt_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  stale_cnt_inc;
    logic              to_hit;
    logic              stale_expire;

    // Saturating increments so the counters never wrap back into range.
    // The comparisons use >= so a gnt accepted in the very last cycle
    // still leaves the response phase bounded.
    always_comb begin
        cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        stale_cnt_inc = (stale_cnt_q == '1) ? stale_cnt_q : stale_cnt_q + 1'b1;
        to_hit        = TO_EN && (cnt_q >= TO_LAST);
        stale_expire  = TO_EN && (stale_cnt_q >= TO_LAST);
    end

    // Next-state, captured fields, OBI drive and command handshake.
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        stale_d        = stale_q;
        stale_cnt_d    = stale_cnt_q;
        cmd_ready_o    = 1'b0;
        regs_req.req   = 1'b0;
        regs_req.we    = 1'b0;
        regs_req.be    = 4'h0;
        regs_req.addr  = 32'h0;
        regs_req.wdata = 32'h0;

        // The orphaned rvalid of a timed-out read is dropped here; if it
        // never shows up the flag expires on its own.
        if (stale_q) begin
            if (regs_rsp.rvalid || stale_expire) begin
                stale_d = 1'b0;
            end else begin
                stale_cnt_d = stale_cnt_inc;
            end
        end

        case (state_q)
            IDLE: begin
                cmd_ready_o = !stale_q;
                if (cmd_valid_i && !stale_q) begin
                    we_d    = cmd_we_i;
                    addr_d  = cmd_addr_i;
                    be_d    = cmd_be_i;
                    wdata_d = cmd_wdata_i;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                regs_req.req   = 1'b1;
                regs_req.we    = we_q;
                regs_req.be    = be_q;
                regs_req.addr  = addr_q;
                regs_req.wdata = wdata_q;
                cnt_d          = cnt_inc;
                if (regs_req.gnt) begin
                    state_d = RESP;
                end else if (to_hit) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RESP: begin
                cnt_d = cnt_inc;
                if (regs_rsp.rvalid) begin
                    rdata_d = we_q ? 32'h0 : regs_rsp.rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (to_hit) begin
                    rdata_d     = 32'h0;
                    err_d       = 1'b1;
                    stale_d     = 1'b1;
                    stale_cnt_d = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-field registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            stale_q     <= 1'b0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            stale_q     <= stale_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign rsp_valid_o = (state_q == DONE);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_cfg_obi_master.sv
// Directed bench for cfg_obi_master with TIMEOUT_CYCLES=8: a vector table of
// normal transactions plus hand-written timeout, stale and reset sequences.

module tb_cfg_obi_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [3:0]  cmd_be_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    obi_req_if req_if ();
    obi_rsp_if rsp_if ();

    cfg_obi_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_be_i    (cmd_be_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .regs_req    (req_if),
        .regs_rsp    (rsp_if)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] slv_rdata;
        int          rdy_dly;
        bit          rv_in_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer a command and return one cycle after acceptance (cycle T+1).
    task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input string nm);
        int guard;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_be_i    = be;
        cmd_wdata_i = wdata;
        guard = 0;
        while (!cmd_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        chk({nm, "_cmd_ready"}, {31'h0, cmd_ready_o}, 32'h1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        issue_cmd(v.we, v.addr, v.be, v.wdata, p);
        // Address phase: fields must be held until the gnt cycle.
        for (int k = 0; k <= v.gnt_dly; k++) begin
            chk({p, "_req"},   {31'h0, req_if.req}, 32'h1);
            chk({p, "_addr"},  req_if.addr, v.addr);
            chk({p, "_we_be"}, {27'h0, req_if.we, req_if.be}, {27'h0, v.we, v.be});
            chk({p, "_wdata"}, req_if.wdata, v.wdata);
            rsp_if.rvalid = v.rv_in_addr;
            rsp_if.rdata  = 32'hBAD0BAD0;
            req_if.gnt    = (k == v.gnt_dly);
            tick();
            req_if.gnt    = 1'b0;
            rsp_if.rvalid = 1'b0;
            rsp_if.rdata  = 32'h0;
        end
        // Response phase.
        for (int k = 0; k <= v.rv_dly; k++) begin
            chk({p, "_req_low"},  {31'h0, req_if.req},  32'h0);
            chk({p, "_addr_low"}, req_if.addr,          32'h0);
            chk({p, "_no_rsp"},   {31'h0, rsp_valid_o}, 32'h0);
            rsp_if.rvalid = (k == v.rv_dly);
            rsp_if.rdata  = (k == v.rv_dly) ? v.slv_rdata : 32'h0;
            tick();
            rsp_if.rvalid = 1'b0;
            rsp_if.rdata  = 32'h0;
        end
        // Response held until consumed.
        for (int k = 0; k <= v.rdy_dly; k++) begin
            chk({p, "_rsp_valid"}, {31'h0, rsp_valid_o}, 32'h1);
            chk({p, "_rdata"},     rsp_rdata_o,          v.exp_rdata);
            chk({p, "_err"},       {31'h0, rsp_err_o},   32'h0);
            chk({p, "_done_ready"}, {30'h0, cmd_ready_o, busy_o}, 32'h1);
            rsp_ready_i = (k == v.rdy_dly);
            tick();
            rsp_ready_i = 1'b0;
        end
        chk({p, "_idle"}, {29'h0, rsp_valid_o, busy_o, cmd_ready_o}, 32'h1);
        $display("txn %s we=%0d addr=%h gnt_dly=%0d rv_dly=%0d rdata=%h err=%0d", p, v.we, v.addr,
                 v.gnt_dly, v.rv_dly, v.exp_rdata, 0);
    endtask

    // Gnt immediately, then withhold rvalid until the timeout fires; leaves
    // the bench in the first IDLE cycle after the error response.
    task automatic resp_timeout(input string p);
        issue_cmd(1'b0, 32'h44, 4'hF, 32'h0, p);
        req_if.gnt = 1'b1;
        tick();
        req_if.gnt = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk({p, "_wait"}, {30'h0, req_if.req, rsp_valid_o}, 32'h0);
            tick();
        end
        chk({p, "_err_rsp"}, {rsp_valid_o, rsp_err_o, 30'h0}, 32'hC0000000);
        chk({p, "_err_rdata"}, rsp_rdata_o, 32'h0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({p, "_blocked"}, {30'h0, busy_o, cmd_ready_o}, 32'h0);
        $display("txn %s read timeout in response phase err=1", p);
    endtask

    initial begin
        rst_i         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_we_i      = 1'b0;
        cmd_addr_i    = 32'h0;
        cmd_be_i      = 4'h0;
        cmd_wdata_i   = 32'h0;
        rsp_ready_i   = 1'b0;
        req_if.gnt    = 1'b0;
        rsp_if.rvalid = 1'b0;
        rsp_if.rdata  = 32'h0;

        //          we    addr      be    wdata      gnt rv slv_rdata   rdy inaddr exp_rdata
        vecs[0] = '{1'b1, 32'h0,    4'hF, 32'h1,     0,  0, 32'hFFFF,   0,  0, 32'h0};
        vecs[1] = '{1'b0, 32'h4,    4'hF, 32'h0,     3,  0, 32'h1,      0,  0, 32'h1};
        vecs[2] = '{1'b0, 32'h100,  4'h3, 32'h0,     0,  2, 32'hCAFEBABE, 5, 0, 32'hCAFEBABE};
        vecs[3] = '{1'b0, 32'h8,    4'hF, 32'h0,     7,  0, 32'h12345678, 0, 0, 32'h12345678};
        vecs[4] = '{1'b0, 32'hC,    4'hC, 32'h0,     0,  6, 32'h0BADF00D, 1, 0, 32'h0BADF00D};
        vecs[5] = '{1'b1, 32'h20,   4'h5, 32'hA5A5,  2,  1, 32'hBEEF0001, 0, 1, 32'h0};

        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_outputs", {27'h0, cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o, req_if.req}, 32'h10);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_addr", req_if.addr, 32'h0);
        $display("txn reset released");

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Address-phase timeout: 8 cycles of req, then error without stale.
        issue_cmd(1'b0, 32'h40, 4'hF, 32'h0, "to_a");
        for (int k = 0; k < 8; k++) begin
            chk("to_a_req", {31'h0, req_if.req}, 32'h1);
            tick();
        end
        chk("to_a_err_rsp", {29'h0, rsp_valid_o, rsp_err_o, req_if.req}, 32'h6);
        chk("to_a_err_rdata", rsp_rdata_o, 32'h0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("to_a_no_stale", {30'h0, busy_o, cmd_ready_o}, 32'h1);
        $display("txn to_a read timeout in address phase err=1");

        // Response timeout, command blocked, late 0xDEAD rvalid swallowed.
        resp_timeout("to_r");
        cmd_valid_i = 1'b1;
        tick();
        chk("to_r_not_accepted", {30'h0, busy_o, cmd_ready_o}, 32'h0);
        cmd_valid_i   = 1'b0;
        rsp_if.rvalid = 1'b1;
        rsp_if.rdata  = 32'hDEAD;
        tick();
        rsp_if.rvalid = 1'b0;
        rsp_if.rdata  = 32'h0;
        chk("to_r_late_dropped", {29'h0, rsp_valid_o, busy_o, cmd_ready_o}, 32'h1);
        chk("to_r_late_rdata", rsp_rdata_o, 32'h0);
        $display("txn to_r late rvalid rdata=0000dead discarded");
        run_vec(vecs[1], 1);

        // Stale flag expires on its own when no rvalid ever arrives.
        resp_timeout("stale");
        for (int k = 0; k < 7; k++) begin
            chk("stale_hold", {31'h0, cmd_ready_o}, 32'h0);
            tick();
        end
        chk("stale_expired", {31'h0, cmd_ready_o}, 32'h1);
        $display("txn stale flag self-cleared");

        // Reset in the response phase abandons the transaction.
        issue_cmd(1'b0, 32'h48, 4'hF, 32'h0, "rst_mid");
        req_if.gnt = 1'b1;
        tick();
        req_if.gnt = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_mid_outputs", {27'h0, cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o, req_if.req}, 32'h10);
        chk("rst_mid_rdata", rsp_rdata_o, 32'h0);
        rsp_if.rvalid = 1'b1;
        rsp_if.rdata  = 32'h777;
        tick();
        rsp_if.rvalid = 1'b0;
        rsp_if.rdata  = 32'h0;
        chk("rst_mid_ignored", {29'h0, rsp_valid_o, busy_o, cmd_ready_o}, 32'h1);
        tick();
        chk("rst_mid_still_idle", {30'h0, rsp_valid_o, busy_o}, 32'h0);
        $display("txn rst_mid reset during response phase, late rvalid ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
